// File: rtl/i2c_mon_pkg.sv
// Shared types and sizing helpers for the multi-bus I2C monitor.
package i2c_mon_pkg;

  typedef enum logic [1:0] {
    REC_START = 2'd0,
    REC_ADDR  = 2'd1,
    REC_DATA  = 2'd2,
    REC_STOP  = 2'd3
  } rec_kind_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT
  } dec_state_t;

  // Per-bus record as held in a decoder; the top inserts bus id and timestamp.
  typedef struct packed {
    rec_kind_t   kind;
    logic [7:0]  data;
    logic        ack;
  } i2c_mon_rec_t;

  function automatic int bid_width(input int num_buses);
    return (num_buses > 1) ? $clog2(num_buses) : 1;
  endfunction

  function automatic int rec_width(input int num_buses, input int ts_w, input bit ts_en);
    return $bits(i2c_mon_rec_t) + bid_width(num_buses) + (ts_en ? ts_w : 0);
  endfunction

endpackage

// File: rtl/i2c_bus_decoder.sv
// One observed I2C bus: synchroniser, glitch filter, protocol FSM, one-entry holding register.
// I2C_MON_TIMESTAMP_EN adds a timestamp captured alongside each held record.
module i2c_bus_decoder
  import i2c_mon_pkg::*;
#(
  parameter int FILTER_LEN = 3
`ifdef I2C_MON_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          scl,
  input  logic          sda,
  input  logic          grant,
`ifdef I2C_MON_TIMESTAMP_EN
  input  logic [TS_W-1:0] ts,
  output logic [TS_W-1:0] rec_ts,
`endif
  output logic          rec_valid,
  output i2c_mon_rec_t  rec,
  output logic          ovf_pulse
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  // Index 1 carries SCL, index 0 carries SDA.
  logic [1:0]       sync1, sync2, filt, filt_q;
  logic [CNT_W-1:0] cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_q <= '1;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the pre-edge value, so the sync chain stays two stages deep.
      sync1  <= {scl, sda};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic start_ev, stop_ev, scl_rise;
  assign start_ev = filt[1] & filt_q[1] &  filt_q[0] & ~filt[0];
  assign stop_ev  = filt[1] & filt_q[1] & ~filt_q[0] &  filt[0];
  assign scl_rise = filt[1] & ~filt_q[1];

  dec_state_t   state, state_next;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift;
  logic         emit;
  i2c_mon_rec_t emit_rec;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else if (start_ev) begin
      state_next = ADDR;
    end else if (stop_ev && state != IDLE) begin
      state_next = IDLE;
    end else if (scl_rise) begin
      unique case (state)
        ADDR:     if (bit_cnt == 3'd7) state_next = ADDR_ACK;
        DATA:     if (bit_cnt == 3'd7) state_next = DATA_ACK;
        ADDR_ACK,
        DATA_ACK: state_next = filt[0] ? WAIT : DATA;
        default:  state_next = state;
      endcase
    end
  end

  always_comb begin
    emit     = 1'b0;
    emit_rec = '0;
    if (enable) begin
      if (start_ev) begin
        emit          = 1'b1;
        emit_rec.kind = REC_START;
      end else if (stop_ev && state != IDLE) begin
        emit          = 1'b1;
        emit_rec.kind = REC_STOP;
      end else if (scl_rise && (state == ADDR_ACK || state == DATA_ACK)) begin
        emit          = 1'b1;
        emit_rec.kind = (state == ADDR_ACK) ? REC_ADDR : REC_DATA;
        emit_rec.data = shift;
        emit_rec.ack  = ~filt[0];
      end
    end
  end

  // Bit counter wraps 7->0 so the first data byte after an ACK starts at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (enable) begin
      if (start_ev) begin
        bit_cnt <= '0;
      end else if (scl_rise && (state == ADDR || state == DATA)) begin
        shift   <= {shift[6:0], filt[0]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  logic load;
  assign ovf_pulse = emit & rec_valid & ~grant;
  assign load      = emit & ~ovf_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_valid <= 1'b0;
      rec       <= '0;
`ifdef I2C_MON_TIMESTAMP_EN
      rec_ts    <= '0;
`endif
    end else if (load) begin
      rec_valid <= 1'b1;
      rec       <= emit_rec;
`ifdef I2C_MON_TIMESTAMP_EN
      rec_ts    <= ts;
`endif
    end else if (grant) begin
      rec_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_multibus_monitor.sv
// Passive multi-bus I2C monitor: per-bus decoders, round-robin arbiter, shared record FIFO.
// I2C_MON_TIMESTAMP_EN appends a free-running cycle timestamp to every record.
module i2c_multibus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int NUM_BUSES  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FILTER_LEN = 3,
  parameter int TS_W       = 16,
`ifdef I2C_MON_TIMESTAMP_EN
  localparam bit TS_EN     = 1'b1,
`else
  localparam bit TS_EN     = 1'b0,
`endif
  localparam int BID_W     = bid_width(NUM_BUSES),
  localparam int REC_W     = rec_width(NUM_BUSES, TS_W, TS_EN),
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [REC_W-1:0]     rec_data_o,
  output logic [AW:0]          fifo_count_o,
  output logic [NUM_BUSES-1:0] overflow_o,
  input  logic                 clear_ovf_i
);

  logic [NUM_BUSES-1:0] hold_valid, grant, ovf_pulse;
  i2c_mon_rec_t         hold_rec [NUM_BUSES];

`ifdef I2C_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] hold_ts [NUM_BUSES];

  always_ff @(posedge clk_i) begin
    if (rst_i) ts <= '0;
    else       ts <= ts + 1'b1;
  end
`endif

  for (genvar g = 0; g < NUM_BUSES; g++) begin : g_bus
    i2c_bus_decoder #(
      .FILTER_LEN (FILTER_LEN)
`ifdef I2C_MON_TIMESTAMP_EN
      , .TS_W     (TS_W)
`endif
    ) u_dec (
      .clk        (clk_i),
      .rst        (rst_i),
      .enable     (enable_i),
      .scl        (scl_i[g]),
      .sda        (sda_i[g]),
      .grant      (grant[g]),
`ifdef I2C_MON_TIMESTAMP_EN
      .ts         (ts),
      .rec_ts     (hold_ts[g]),
`endif
      .rec_valid  (hold_valid[g]),
      .rec        (hold_rec[g]),
      .ovf_pulse  (ovf_pulse[g])
    );
  end

  logic             pop, wr_room, wr_en;
  logic [BID_W-1:0] rr_ptr, gnt_idx;
  logic [REC_W-1:0] wr_word;
  int               idx;

  assign pop     = rec_valid_o & rec_ready_i;
  assign wr_room = (fifo_count_o < (AW+1)'(FIFO_DEPTH)) | pop;

  // Round-robin search starting at rr_ptr; first valid holding register wins.
  always_comb begin
    wr_en   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    idx     = 0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_BUSES) idx = idx - NUM_BUSES;
      if (!wr_en && wr_room && hold_valid[idx]) begin
        wr_en   = 1'b1;
        gnt_idx = BID_W'(idx);
      end
    end
    if (wr_en) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    wr_word = {hold_rec[gnt_idx].kind, gnt_idx, hold_rec[gnt_idx].data, hold_rec[gnt_idx].ack
`ifdef I2C_MON_TIMESTAMP_EN
               , hold_ts[gnt_idx]
`endif
              };
  end

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // NOTE: the FIFO storage has no reset; rec_data_o is forced to 0 while empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      rr_ptr       <= '0;
      overflow_o   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_idx == BID_W'(NUM_BUSES - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count_o <= fifo_count_o + 1'b1;
        2'b01:   fifo_count_o <= fifo_count_o - 1'b1;
        default: fifo_count_o <= fifo_count_o;
      endcase
      // A new drop in the clearing cycle wins over the clear.
      overflow_o <= (overflow_o & ~{NUM_BUSES{clear_ovf_i}}) | ovf_pulse;
    end
  end

  assign rec_valid_o = (fifo_count_o != '0);
  assign rec_data_o  = rec_valid_o ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_i2c_multibus_monitor.sv
// Scoreboard bench for i2c_multibus_monitor (4 buses, 4-entry FIFO, 3-sample filter).
module tb_i2c_multibus_monitor;
  import i2c_mon_pkg::*;

  localparam int NB   = 4;
  localparam int FD   = 4;
  localparam int CORE = 13;
`ifdef I2C_MON_TIMESTAMP_EN
  localparam int TSW  = 16;
`else
  localparam int TSW  = 0;
`endif
  localparam int REC_W = CORE + TSW;
  localparam int Q     = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic [NB-1:0]    scl = '1;
  logic [NB-1:0]    sda = '1;
  logic             rec_valid;
  logic             rec_ready = 1'b0;
  logic [REC_W-1:0] rec_data;
  logic [2:0]       fifo_count;
  logic [NB-1:0]    overflow;
  logic             clear_ovf = 1'b0;

  i2c_multibus_monitor #(
    .NUM_BUSES  (NB),
    .FIFO_DEPTH (FD),
    .FILTER_LEN (3),
    .TS_W       (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .scl_i        (scl),
    .sda_i        (sda),
    .rec_valid_o  (rec_valid),
    .rec_ready_i  (rec_ready),
    .rec_data_o   (rec_data),
    .fifo_count_o (fifo_count),
    .overflow_o   (overflow),
    .clear_ovf_i  (clear_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CORE-1:0] sb [$];
  logic [CORE-1:0] exp_rec;
`ifdef I2C_MON_TIMESTAMP_EN
  logic [TSW-1:0]  ts_q [$];
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [CORE-1:0] mk(input rec_kind_t k, input int bus, input logic [7:0] b,
                                         input logic ack);
    return {k, 2'(bus), b, ack};
  endfunction

  task automatic push(input rec_kind_t k, input int bus, input logic [7:0] b, input logic ack);
    sb.push_back(mk(k, bus, b, ack));
  endtask

  // Pop side of the scoreboard: every record leaving the FIFO is compared in order.
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_rec = sb.pop_front();
        check("record", rec_data[REC_W-1 -: CORE], exp_rec);
      end
`ifdef I2C_MON_TIMESTAMP_EN
      ts_q.push_back(rec_data[TSW-1:0]);
`endif
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_scl(input logic [NB-1:0] m, input logic v);
    scl = (scl & ~m) | (m & {NB{v}});
  endtask

  task automatic set_sda(input logic [NB-1:0] m, input logic v);
    sda = (sda & ~m) | (m & {NB{v}});
  endtask

  task automatic i2c_start(input logic [NB-1:0] m);
    set_sda(m, 1'b1); wait_clk(Q);
    set_scl(m, 1'b1); wait_clk(Q);
    set_sda(m, 1'b0); wait_clk(Q);
    set_scl(m, 1'b0); wait_clk(Q);
  endtask

  task automatic i2c_bit(input logic [NB-1:0] m, input logic v);
    set_sda(m, v);    wait_clk(Q);
    set_scl(m, 1'b1); wait_clk(2*Q);
    set_scl(m, 1'b0); wait_clk(Q);
  endtask

  task automatic i2c_byte(input logic [NB-1:0] m, input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(m, b[i]);
    i2c_bit(m, ~ack);
  endtask

  task automatic i2c_stop(input logic [NB-1:0] m);
    set_sda(m, 1'b0); wait_clk(Q);
    set_scl(m, 1'b1); wait_clk(Q);
    set_sda(m, 1'b1); wait_clk(Q);
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    for (int i = 0; i < 400 && (sb.size() != 0 || rec_valid); i++) wait_clk(1);
    wait_clk(4);
    check("drain_sb_empty", sb.size(), 0);
    check("drain_fifo_empty", rec_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    sb.delete();
    wait_clk(2);
  endtask

  initial begin
    wait_clk(3);
    check("rst_valid", rec_valid, 0);
    check("rst_data", rec_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    wait_clk(4);

    // Simple write transaction, held in the FIFO.
    push(REC_START, 0, 8'h00, 1'b0); i2c_start(4'b0001);
    push(REC_ADDR,  0, 8'h84, 1'b1); i2c_byte(4'b0001, 8'h84, 1'b1);
    push(REC_DATA,  0, 8'hA5, 1'b1); i2c_byte(4'b0001, 8'hA5, 1'b1);
    push(REC_STOP,  0, 8'h00, 1'b0); i2c_stop(4'b0001);
    wait_clk(10);
    check("t1_count", fifo_count, 4);
    check("t1_valid", rec_valid, 1);
    drain();

    // Repeated START and a NACKed read; the trailing byte must be ignored.
    push(REC_START, 0, 8'h00, 1'b0); i2c_start(4'b0001);
    push(REC_ADDR,  0, 8'h84, 1'b1); i2c_byte(4'b0001, 8'h84, 1'b1);
    push(REC_DATA,  0, 8'h01, 1'b1); i2c_byte(4'b0001, 8'h01, 1'b1);
    push(REC_START, 0, 8'h00, 1'b0); i2c_start(4'b0001);
    push(REC_ADDR,  0, 8'h85, 1'b1); i2c_byte(4'b0001, 8'h85, 1'b1);
    push(REC_DATA,  0, 8'h3C, 1'b0); i2c_byte(4'b0001, 8'h3C, 1'b0);
    i2c_byte(4'b0001, 8'h55, 1'b1);
    push(REC_STOP,  0, 8'h00, 1'b0); i2c_stop(4'b0001);
    drain();

    // enable_i dropped mid-byte: no further records, trailing STOP lands in IDLE.
    push(REC_START, 3, 8'h00, 1'b0); i2c_start(4'b1000);
    for (int i = 0; i < 3; i++) i2c_bit(4'b1000, 1'b1);
    enable = 1'b0; wait_clk(3); enable = 1'b1;
    for (int i = 0; i < 6; i++) i2c_bit(4'b1000, 1'b0);
    i2c_stop(4'b1000);
    drain();

    // One-cycle SDA glitch while SCL is high must be filtered out.
    set_sda(4'b0100, 1'b0); wait_clk(1); set_sda(4'b0100, 1'b1);
    wait_clk(20);
    check("glitch_count", fifo_count, 0);
    check("glitch_valid", rec_valid, 0);

    // Reset mid-byte clears everything; a following clean transfer decodes.
    rec_ready = 1'b0;
    i2c_start(4'b0100);
    for (int i = 0; i < 3; i++) i2c_bit(4'b0100, 1'b1);
    check("pre_rst_count", fifo_count, 1);
    rst = 1'b1;
    wait_clk(1);
    check("midrst_valid", rec_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_data", rec_data, 0);
    check("midrst_ovf", overflow, 0);
    set_sda(4'b0100, 1'b1); wait_clk(2); set_scl(4'b0100, 1'b1);
    wait_clk(10);
    rst = 1'b0;
    wait_clk(10);
    rec_ready = 1'b1;
    push(REC_START, 2, 8'h00, 1'b0); i2c_start(4'b0100);
    push(REC_ADDR,  2, 8'h84, 1'b1); i2c_byte(4'b0100, 8'h84, 1'b1);
    push(REC_STOP,  2, 8'h00, 1'b0); i2c_stop(4'b0100);
    drain();

    // Simultaneous events on all buses, arbiter pointer fresh from reset.
    do_reset();
    rec_ready = 1'b1;
    for (int b = 0; b < NB; b++) push(REC_START, b, 8'h00, 1'b0);
    i2c_start(4'b1111);
    for (int b = 0; b < NB; b++) push(REC_STOP, b, 8'h00, 1'b0);
    i2c_stop(4'b1111);
    drain();
    check("t3_ovf", overflow, 0);

    // Overflow: FIFO (4) + holding register (1) keep 5 of 8 events on bus 1.
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2*i < 5)     push(REC_START, 1, 8'h00, 1'b0);
      i2c_start(4'b0010);
      if (2*i + 1 < 5) push(REC_STOP, 1, 8'h00, 1'b0);
      i2c_stop(4'b0010);
    end
    wait_clk(10);
    check("t4_count", fifo_count, 4);
    check("t4_ovf", overflow, 4'b0010);
    clear_ovf = 1'b1; wait_clk(1); clear_ovf = 1'b0; wait_clk(1);
    check("t4_ovf_clear", overflow, 0);
    drain();

`ifdef I2C_MON_TIMESTAMP_EN
    // Two STOPs 100 cycles apart on buses 0 and 1.
    ts_q.delete();
    push(REC_START, 0, 8'h00, 1'b0);
    push(REC_START, 1, 8'h00, 1'b0);
    i2c_start(4'b0011);
    push(REC_STOP, 0, 8'h00, 1'b0);
    push(REC_STOP, 1, 8'h00, 1'b0);
    set_scl(4'b0011, 1'b1); wait_clk(Q);
    set_sda(4'b0001, 1'b1); wait_clk(100);
    set_sda(4'b0010, 1'b1); wait_clk(Q);
    drain();
    check("ts_records", ts_q.size(), 4);
    if (ts_q.size() == 4) check("ts_delta", 16'(ts_q[3] - ts_q[2]), 100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
